// File: rtl/tnkk_accum_stage_pkg.sv
// Shared definitions for the tnkk accumulation stage: FSM encoding,
// default widths and the lane-count / tree-depth derivations.
package tnkk_accum_stage_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        DRAIN = 3'd2,
        SCALE = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam int unsigned DEF_TN            = 4;
    localparam int unsigned DEF_KERNEL_SIZE   = 3;
    localparam int unsigned DEF_FEATURE_WIDTH = 8;
    localparam int unsigned DEF_BIAS_WIDTH    = 16;
    localparam int unsigned DEF_SCALER_WIDTH  = 16;
    localparam int unsigned DEF_ACC_WIDTH     = 24;
    localparam int unsigned DEF_OUT_SHIFT     = 8;

    function automatic int unsigned nprod(input int unsigned tn, input int unsigned k);
        return tn * k * k;
    endfunction

    function automatic int unsigned tree_stages(input int unsigned lanes);
        return $clog2(lanes);
    endfunction

    localparam int unsigned DEF_NPROD       = nprod(DEF_TN, DEF_KERNEL_SIZE);
    localparam int unsigned DEF_TREE_STAGES = tree_stages(DEF_NPROD);

endpackage

// File: rtl/tnkk_accum_stage_if.sv
// Beat-in / result-out handshake bundle for tnkk_accum_stage.
interface tnkk_accum_stage_if
    import tnkk_accum_stage_pkg::*;
#(
    parameter int unsigned FEATURE_WIDTH = DEF_FEATURE_WIDTH,
    parameter int unsigned NPROD         = DEF_NPROD,
    parameter int unsigned BIAS_WIDTH    = DEF_BIAS_WIDTH,
    parameter int unsigned SCALER_WIDTH  = DEF_SCALER_WIDTH
);
    logic [NPROD*FEATURE_WIDTH-1:0] product_in;
    logic                           in_valid;
    logic                           in_ready;
    logic                           in_last;
    logic [BIAS_WIDTH-1:0]          bias_in;
    logic [SCALER_WIDTH-1:0]        scaler_in;
    logic [FEATURE_WIDTH-1:0]       out_data;
    logic                           out_valid;
    logic                           out_ready;
    logic                           acc_overflow;

    modport master (
        output product_in, in_valid, in_last, bias_in, scaler_in, out_ready,
        input  in_ready, out_data, out_valid, acc_overflow
    );

    modport slave (
        input  product_in, in_valid, in_last, bias_in, scaler_in, out_ready,
        output in_ready, out_data, out_valid, acc_overflow
    );
endinterface

// File: rtl/tnkk_adder_tree.sv
// Fully pipelined, never-stalling binary adder tree with valid/last sideband.
// Each level halves the node count (odd node passes through, still registered).
module tnkk_adder_tree
    import tnkk_accum_stage_pkg::*;
#(
    parameter int unsigned LANES      = DEF_NPROD,
    parameter int unsigned LANE_WIDTH = DEF_FEATURE_WIDTH
)(
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    input  logic                                        in_last,
    input  logic [LANES*LANE_WIDTH-1:0]                 in_data,
    output logic                                        out_valid,
    output logic                                        out_last,
    output logic [LANE_WIDTH+tree_stages(LANES)-1:0]    out_sum
);
    localparam int unsigned STAGES    = tree_stages(LANES);
    localparam int unsigned SUM_WIDTH = LANE_WIDTH + STAGES;

    function automatic int unsigned level_count(input int unsigned l);
        return (LANES + (32'd1 << l) - 32'd1) >> l;
    endfunction

    function automatic int unsigned level_base(input int unsigned l);
        int unsigned b;
        b = 0;
        for (int unsigned k = 1; k < l; k++) b += level_count(k);
        return b;
    endfunction

    localparam int unsigned NODES = level_base(STAGES + 1);

    logic [SUM_WIDTH-1:0] node      [NODES];
    logic [SUM_WIDTH-1:0] node_next [NODES];
    logic [STAGES-1:0]    valid_sr;
    logic [STAGES-1:0]    last_sr;

    // All levels live in one flat array; level l starts at level_base(l).
    always_comb begin
        node_next = '{default: '0};
        for (int unsigned j = 0; j < level_count(1); j++) begin
            node_next[j] = SUM_WIDTH'(in_data[2*j*LANE_WIDTH +: LANE_WIDTH]);
            if (2*j + 1 < LANES)
                node_next[j] = node_next[j]
                             + SUM_WIDTH'(in_data[(2*j+1)*LANE_WIDTH +: LANE_WIDTH]);
        end
        for (int unsigned l = 2; l <= STAGES; l++) begin
            for (int unsigned j = 0; j < level_count(l); j++) begin
                node_next[level_base(l)+j] = node[level_base(l-1)+2*j];
                if (2*j + 1 < level_count(l-1))
                    node_next[level_base(l)+j] = node_next[level_base(l)+j]
                                               + node[level_base(l-1)+2*j+1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            node     <= '{default: '0};
            valid_sr <= '0;
            last_sr  <= '0;
        end else begin
            node     <= node_next;
            valid_sr <= STAGES'({valid_sr, in_valid});
            last_sr  <= STAGES'({last_sr, in_last});
        end
    end

    assign out_sum   = node[NODES-1];
    assign out_valid = valid_sr[STAGES-1];
    assign out_last  = last_sr[STAGES-1];

endmodule

// File: rtl/tnkk_accum_stage.sv
// Accumulates adder-tree sums over channel-tile beats, then biases, scales and
// shifts the pixel result. Define ACCUM_SATURATE_EN to clamp instead of truncate.
module tnkk_accum_stage
    import tnkk_accum_stage_pkg::*;
#(
    parameter int unsigned Tn            = DEF_TN,
    parameter int unsigned KERNEL_SIZE   = DEF_KERNEL_SIZE,
    parameter int unsigned FEATURE_WIDTH = DEF_FEATURE_WIDTH,
    parameter int unsigned BIAS_WIDTH    = DEF_BIAS_WIDTH,
    parameter int unsigned SCALER_WIDTH  = DEF_SCALER_WIDTH,
    parameter int unsigned ACC_WIDTH     = DEF_ACC_WIDTH,
    parameter int unsigned OUT_SHIFT     = DEF_OUT_SHIFT
)(
    input  logic               clk,
    input  logic               rst,
    tnkk_accum_stage_if.slave  bus
);
    localparam int unsigned NPROD       = nprod(Tn, KERNEL_SIZE);
    localparam int unsigned TREE_STAGES = tree_stages(NPROD);
    localparam int unsigned SUM_W       = FEATURE_WIDTH + TREE_STAGES;
    localparam int unsigned TOT_W       = ((ACC_WIDTH > SUM_W) ? ACC_WIDTH : SUM_W) + 1;
    localparam int unsigned AB_W        = ((ACC_WIDTH > BIAS_WIDTH) ? ACC_WIDTH : BIAS_WIDTH) + 1;
    localparam int unsigned PROD_W      = AB_W + SCALER_WIDTH;
    localparam logic [FEATURE_WIDTH-1:0] RES_MAX = '1;

    state_t state, state_next;

    logic                           ready_q;
    logic                           accept;
    logic [NPROD*FEATURE_WIDTH-1:0] lanes_q;
    logic                           lanes_valid_q;
    logic                           lanes_last_q;
    logic [BIAS_WIDTH-1:0]          bias_q;
    logic [SCALER_WIDTH-1:0]        scaler_q;
    logic                           tree_valid;
    logic                           tree_last;
    logic [SUM_W-1:0]               tree_sum;
    logic [ACC_WIDTH-1:0]           acc;
    logic [TOT_W-1:0]               acc_total;
    logic                           acc_carry;
    logic [PROD_W-1:0]              scaled;
    logic [FEATURE_WIDTH-1:0]       result;
    logic [FEATURE_WIDTH-1:0]       out_data_q;
    logic                           out_valid_q;
    logic                           overflow_q;

    assign accept = bus.in_valid & ready_q;

    // Input capture register; rejected beats enter the tree as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lanes_q       <= '0;
            lanes_valid_q <= 1'b0;
            lanes_last_q  <= 1'b0;
            bias_q        <= '0;
            scaler_q      <= '0;
        end else begin
            lanes_q       <= accept ? bus.product_in : '0;
            lanes_valid_q <= accept;
            lanes_last_q  <= accept & bus.in_last;
            if (accept && bus.in_last) begin
                bias_q   <= bus.bias_in;
                scaler_q <= bus.scaler_in;
            end
        end
    end

    tnkk_adder_tree #(
        .LANES      (NPROD),
        .LANE_WIDTH (FEATURE_WIDTH)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (lanes_valid_q),
        .in_last   (lanes_last_q),
        .in_data   (lanes_q),
        .out_valid (tree_valid),
        .out_last  (tree_last),
        .out_sum   (tree_sum)
    );

    always_comb begin
        acc_total = TOT_W'(acc) + TOT_W'(tree_sum);
        acc_carry = |acc_total[TOT_W-1:ACC_WIDTH];
        scaled    = ((PROD_W'(acc) + PROD_W'(bias_q)) * PROD_W'(scaler_q)) >> OUT_SHIFT;
`ifdef ACCUM_SATURATE_EN
        result    = (scaled > PROD_W'(RES_MAX)) ? RES_MAX : FEATURE_WIDTH'(scaled);
`else
        result    = FEATURE_WIDTH'(scaled);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = bus.in_last ? DRAIN : ACCUM;
            ACCUM:   if (accept && bus.in_last) state_next = DRAIN;
            DRAIN:   if (tree_valid && tree_last) state_next = SCALE;
            SCALE:   state_next = HOLD;
            HOLD:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // in_ready is registered from the next state so it stays low through reset
    // and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q     <= 1'b0;
            acc         <= '0;
            overflow_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ready_q <= (state_next == IDLE) || (state_next == ACCUM);
            if (state == HOLD && bus.out_ready) begin
                acc         <= '0;
                out_valid_q <= 1'b0;
            end else if (tree_valid) begin
                acc <= acc_total[ACC_WIDTH-1:0];
                if (acc_carry) overflow_q <= 1'b1;
            end
            if (state == SCALE) begin
                out_data_q  <= result;
                out_valid_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready     = ready_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.acc_overflow = overflow_q;

endmodule
